nn_sequencer: RTL
=================

Name: nn_sequencer

Overview:
Top-level inference controller for the digit-recognition network. On a start request it sequences hidden layer then output layer through their go/done handshakes. It then scans the OL_neurons post-ReLU output scores serially and reports the winning digit with its score. A per-stage watchdog aborts if a layer never signals done.

Parameters:
OL_neurons, 10, number of output scores to scan (max 16)
WIDTH, 8, base data width; each score is 5*WIDTH bits signed
TIMEOUT_CYCLES, 4096, max cycles allowed between a go pulse and its done before abort

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to run one inference; ignored unless idle
busy  output  1  high from the cycle after an accepted start until the done/error pulse cycle, inclusive
hidden_go  output  1  one-cycle pulse launching the hidden layer
hidden_done  input  1  hidden layer completion (level or pulse)
output_go  output  1  one-cycle pulse launching the output layer
output_done  input  1  output layer completion (level or pulse)
scores  input  5*WIDTH*OL_neurons  output-layer scores; score i = bits [5*WIDTH*i +: 5*WIDTH], signed
digit  output  4  index of the maximum score; held until next result
max_score  output  5*WIDTH  value of the maximum score, signed; held until next result
result_valid  output  1  one-cycle pulse when digit/max_score update
error  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE; busy, hidden_go, output_go, result_valid, error = 0; digit = 0; max_score = 0; counters = 0. Reset mid-run aborts immediately; no go pulse or result is emitted afterwards.
- States: IDLE, HL_WAIT, OL_WAIT, SCAN, REPORT.
- IDLE: start=1 at cycle T → hidden_go=1 at T+1; state HL_WAIT; busy=1 from T+1.
- HL_WAIT: hidden_done is sampled starting the cycle after hidden_go. On hidden_done=1, output_go pulses next cycle and state becomes OL_WAIT.
- OL_WAIT: same rule with output_done. On output_done=1 the scores vector is latched the same edge; state becomes SCAN with idx=1, best=score0, best_idx=0.
- SCAN: one compare per cycle on the latched copy. If score[idx] > best (signed, strict), then best=score[idx] and best_idx=idx. After idx = OL_neurons-1, go to REPORT. Ties resolve to the lowest index.
- REPORT: digit=best_idx, max_score=best, result_valid=1 for one cycle, busy=0 next cycle, state IDLE.
- Latency from output_done to result_valid is exactly OL_neurons+1 cycles (11 at default).
- Watchdog: counter clears on each go pulse and increments in HL_WAIT/OL_WAIT. On reaching TIMEOUT_CYCLES with no done: error=1 for one cycle, then IDLE; digit/max_score keep their previous values; result_valid stays 0.
- start while busy is ignored, with no queuing.
- A done input asserted while not in its wait state is ignored.
- Counter widths: idx is $clog2(OL_neurons) bits; watchdog is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package: state encoding (IDLE..REPORT), SCORE_W = 5*WIDTH constant, digit width 4.
- Natural sub-module: argmax_scan (latched vector, start/done, serial signed compare, lowest-index tie-break), reusable for any layer output.
- FSM and watchdog stay in nn_sequencer.

Test Plan:
- Nominal run: start at cycle 0; hidden_done 5 cycles after hidden_go; output_done 3 cycles after output_go; score3=1000, others ≤500 → result_valid exactly 11 cycles after output_done, digit=3, max_score=1000, error never asserted.
- Tie: scores 2 and 7 both equal 0x00_0000_0400, others 0 → digit=2. All scores zero → digit=0, max_score=0.
- Watchdog: hidden_done held low → error pulse at go+TIMEOUT_CYCLES, output_go never asserted, digit/max_score unchanged from the prior run, busy drops; a following start runs normally.
- start spam: start held high for 30 cycles across a run → exactly one hidden_go, one output_go and one result_valid per accepted start; a new run begins only after returning to IDLE.
- Reset mid-SCAN: assert reset at idx=4 → next cycle all outputs are at reset values; no result_valid afterwards; the next start completes correctly.
- Stray done: output_done pulsed during HL_WAIT → ignored; sequence completes with the correct order of hidden_go then output_go.

Source files
------------

// File: rtl/nn_sequencer_pkg.sv
// rtl/nn_sequencer_pkg.sv - shared state encoding and widths for the inference sequencer
package nn_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HL_WAIT,
        S_OL_WAIT,
        S_SCAN,
        S_REPORT
    } state_t;

    localparam int DIGIT_W       = 4;
    localparam int SCORE_MULT    = 5;
    localparam int DEFAULT_WIDTH = 8;
    localparam int SCORE_W       = SCORE_MULT * DEFAULT_WIDTH;

    function automatic int score_w(input int width);
        return SCORE_MULT * width;
    endfunction

endpackage

// File: rtl/nn_sequencer_argmax_scan.sv
// rtl/nn_sequencer_argmax_scan.sv - serial signed argmax over a latched score vector
module nn_sequencer_argmax_scan #(
    parameter int N  = 10,
    parameter int SW = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SW*N-1:0]        vec,
    output logic                   last,
    output logic [SW-1:0]          best,
    output logic [$clog2(N)-1:0]   best_idx
);
    import nn_sequencer_pkg::*;

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [SW-1:0]    lat [N];
    logic [IDX_W-1:0] idx;
    logic             running;

    assign last = running && (idx == IDX_LAST);

    // Strict greater-than keeps the earliest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (start) begin
            for (int i = 0; i < N; i++) begin
                lat[i] <= vec[SW*i +: SW];
            end
            idx      <= IDX_W'(1);
            best     <= vec[SW-1:0];
            best_idx <= '0;
            running  <= 1'b1;
        end else if (running) begin
            if ($signed(lat[idx]) > $signed(best)) begin
                best     <= lat[idx];
                best_idx <= idx;
            end
            if (last) begin
                running <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_sequencer.sv
// rtl/nn_sequencer.sv - hidden/output layer sequencing, watchdog and winning-digit report
module nn_sequencer
    import nn_sequencer_pkg::*;
#(
    parameter int OL_neurons     = 10,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  hidden_go,
    input  logic                                  hidden_done,
    output logic                                  output_go,
    input  logic                                  output_done,
    input  logic [score_w(WIDTH)*OL_neurons-1:0]  scores,
    output logic [DIGIT_W-1:0]                    digit,
    output logic [score_w(WIDTH)-1:0]             max_score,
    output logic                                  result_valid,
    output logic                                  error
);

    localparam int SW    = score_w(WIDTH);
    localparam int IDX_W = $clog2(OL_neurons);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [WD_W-1:0]  wdog;
    logic             scan_start;
    logic             scan_last;
    logic [SW-1:0]    scan_best;
    logic [IDX_W-1:0] scan_best_idx;

    // Done inputs are not trusted during the go cycle itself.
    assign scan_start = (state == S_OL_WAIT) && !output_go && output_done;

    nn_sequencer_argmax_scan #(
        .N  (OL_neurons),
        .SW (SW)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .start    (scan_start),
        .vec      (scores),
        .last     (scan_last),
        .best     (scan_best),
        .best_idx (scan_best_idx)
    );

    // busy stays high through the result/error pulse cycle, which is spent in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            hidden_go    <= 1'b0;
            output_go    <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            digit        <= '0;
            max_score    <= '0;
            wdog         <= '0;
        end else begin
            hidden_go    <= 1'b0;
            output_go    <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy      <= 1'b1;
                        hidden_go <= 1'b1;
                        wdog      <= '0;
                        state     <= S_HL_WAIT;
                    end
                end
                S_HL_WAIT: begin
                    if (!hidden_go && hidden_done) begin
                        output_go <= 1'b1;
                        wdog      <= '0;
                        state     <= S_OL_WAIT;
                    end else if (wdog == WD_LAST) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_OL_WAIT: begin
                    if (scan_start) begin
                        state <= S_SCAN;
                    end else if (wdog == WD_LAST) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_last) begin
                        state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    digit        <= DIGIT_W'(scan_best_idx);
                    max_score    <= scan_best;
                    result_valid <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
